// File: rtl/ay_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ay_pkg : bus modes, FSM states, register indices and width masks
// Rev 1.0
// ------------------------------------------------------------------
package ay_pkg;

  typedef enum logic [1:0] {
    AY_INACT = 2'b00,
    AY_READ  = 2'b01,
    AY_WRITE = 2'b10,
    AY_LATCH = 2'b11
  } ay_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } ay_state_t;

  localparam logic [3:0] R_TONE_A_L  = 4'd0;
  localparam logic [3:0] R_TONE_A_H  = 4'd1;
  localparam logic [3:0] R_TONE_B_L  = 4'd2;
  localparam logic [3:0] R_TONE_B_H  = 4'd3;
  localparam logic [3:0] R_TONE_C_L  = 4'd4;
  localparam logic [3:0] R_TONE_C_H  = 4'd5;
  localparam logic [3:0] R_NOISE     = 4'd6;
  localparam logic [3:0] R_MIXER     = 4'd7;
  localparam logic [3:0] R_VOL_A     = 4'd8;
  localparam logic [3:0] R_VOL_B     = 4'd9;
  localparam logic [3:0] R_VOL_C     = 4'd10;
  localparam logic [3:0] R_ENV_L     = 4'd11;
  localparam logic [3:0] R_ENV_H     = 4'd12;
  localparam logic [3:0] R_ENV_SHAPE = 4'd13;
  localparam logic [3:0] R_PORT_A    = 4'd14;
  localparam logic [3:0] R_PORT_B    = 4'd15;

  // Implemented bits per register, index 15 first; unimplemented bits read as 0.
  localparam logic [15:0][7:0] REG_MASK = {
    8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F,
    8'hFF, 8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  function automatic ay_state_t mode_to_state(input ay_mode_t m);
    case (m)
      AY_LATCH: mode_to_state = LATCH;
      AY_WRITE: mode_to_state = WRITE;
      AY_READ:  mode_to_state = READ;
      default:  mode_to_state = IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ay_bus_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// ay_bus_sync : BC1/BDIR synchronizer with equal-depth data delay line
// Rev 1.0
// ------------------------------------------------------------------
module ay_bus_sync
  import ay_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bc1,
  input  logic       bdir,
  input  logic [7:0] d_in,
  output ay_mode_t   mode,
  output logic [7:0] data
);

  ay_mode_t   mode_pipe [SYNC_STAGES];
  logic [7:0] data_pipe [SYNC_STAGES];

  // Data travels the same number of stages so each sample lines up with its mode.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        mode_pipe[i] <= AY_INACT;
        data_pipe[i] <= 8'h00;
      end
    end else begin
      mode_pipe[0] <= ay_mode_t'({bdir, bc1});
      data_pipe[0] <= d_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mode_pipe[i] <= mode_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign mode = mode_pipe[SYNC_STAGES-1];
  assign data = data_pipe[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ay_psg_regfile.sv
`default_nettype none
// ------------------------------------------------------------------
// ay_psg_regfile : AY-3-8910 chip-side bus FSM, register file, read mux
// Rev 1.0
// ------------------------------------------------------------------
module ay_psg_regfile
  import ay_pkg::*;
#(
  parameter logic [3:0] CHIP_SEL    = 4'h0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        bc1,
  input  logic        bdir,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic [11:0] tone_a,
  output logic [11:0] tone_b,
  output logic [11:0] tone_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  vol_a,
  output logic [4:0]  vol_b,
  output logic [4:0]  vol_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        env_restart,
  output logic [7:0]  port_a_out,
  output logic [7:0]  port_b_out,
  input  logic [7:0]  port_a_in,
  input  logic [7:0]  port_b_in
);

  ay_mode_t   mode;
  logic [7:0] data;

  ay_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .bc1   (bc1),
    .bdir  (bdir),
    .d_in  (d_in),
    .mode  (mode),
    .data  (data)
  );

  ay_state_t  state;
  ay_state_t  next_state;
  logic [7:0] held;
  logic [3:0] addr;
  logic       selected;
  logic [7:0] regs [16];

  logic       commit_latch;
  logic       commit_write;
  logic [3:0] addr_nx;
  logic       sel_nx;
  logic       rd_en;
  logic [7:0] rd_val;

  // held is the aligned data from the last cycle spent in the current state,
  // so a commit on exit always uses the final stable sample of the phase.
  always_comb begin
    next_state   = mode_to_state(mode);
    commit_latch = (state == LATCH) && (next_state != LATCH);
    commit_write = (state == WRITE) && (next_state != WRITE) && selected;
    addr_nx      = addr;
    sel_nx       = selected;
    if (commit_latch) begin
      if (held[7:4] == CHIP_SEL) begin
        addr_nx = held[3:0];
        sel_nx  = 1'b1;
      end else begin
        sel_nx  = 1'b0;
      end
    end
    rd_en = (next_state == READ) && sel_nx;
    case (addr_nx)
      R_PORT_A: rd_val = regs[R_MIXER][6] ? regs[R_PORT_A] : port_a_in;
      R_PORT_B: rd_val = regs[R_MIXER][7] ? regs[R_PORT_B] : port_b_in;
      default:  rd_val = regs[addr_nx] & REG_MASK[addr_nx];
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      held        <= 8'h00;
      addr        <= 4'h0;
      selected    <= 1'b1;
      d_out       <= 8'h00;
      d_oe        <= 1'b0;
      env_restart <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      state       <= next_state;
      held        <= data;
      addr        <= addr_nx;
      selected    <= sel_nx;
      env_restart <= commit_write && (addr == R_ENV_SHAPE);
      if (commit_write) begin
        regs[addr] <= held & REG_MASK[addr];
      end
      d_oe  <= rd_en;
      d_out <= rd_en ? rd_val : 8'h00;
    end
  end

  assign tone_a       = {regs[R_TONE_A_H][3:0], regs[R_TONE_A_L]};
  assign tone_b       = {regs[R_TONE_B_H][3:0], regs[R_TONE_B_L]};
  assign tone_c       = {regs[R_TONE_C_H][3:0], regs[R_TONE_C_L]};
  assign noise_period = regs[R_NOISE][4:0];
  assign mixer        = regs[R_MIXER];
  assign vol_a        = regs[R_VOL_A][4:0];
  assign vol_b        = regs[R_VOL_B][4:0];
  assign vol_c        = regs[R_VOL_C][4:0];
  assign env_period   = {regs[R_ENV_H], regs[R_ENV_L]};
  assign env_shape    = regs[R_ENV_SHAPE][3:0];
  assign port_a_out   = regs[R_PORT_A];
  assign port_b_out   = regs[R_PORT_B];

endmodule
`default_nettype wire

// File: doc/ay_psg_regfile.md
# ay_psg_regfile

AY-3-8910-compatible chip-side bus interface and register file: the receiving end of the BC1/BDIR handshake that the bus decoder generates for ports FFFD and BFFD. It sits in the sound-core clock domain, which is the AY clock. It synchronizes BC1/BDIR/data, latches the register address, commits register writes, and drives read-back data. The decoded register outputs feed the tone, noise and envelope generators.

## Interface
Parameters:
- CHIP_SEL, 4'h0 — required value of d_in[7:4] on an address latch for the chip to be selected.
- SYNC_STAGES, 2 — synchronizer depth for bc1/bdir; the data pipeline uses the same depth.

Ports:
- clk  in  1  AY clock; all logic is on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- bc1, bdir  in  1 each  bus mode, asynchronous to clk: 00 inactive, 01 read (bc1=1), 10 write, 11 latch address. BC2 is treated as tied high.
- d_in  in  8  bus data, asynchronous.
- d_out  out  8  read-back data, registered.
- d_oe  out  1  read-back drive enable.
- tone_a, tone_b, tone_c  out  12 each  {R1[3:0],R0}, {R3[3:0],R2}, {R5[3:0],R4}.
- noise_period  out  5  R6[4:0].
- mixer  out  8  R7.
- vol_a, vol_b, vol_c  out  5 each  R8, R9, R10, bits [4:0].
- env_period  out  16  {R12,R11}.
- env_shape  out  4  R13[3:0].
- env_restart  out  1  one-cycle pulse on every R13 write.
- port_a_out, port_b_out  out  8 each  R14, R15 output latches.
- port_a_in, port_b_in  in  8 each  external I/O port pins, already synchronous to clk.

## Operation
- The synchronized mode is the SYNC_STAGES-deep registered {bdir,bc1}.
- d_in passes through an equal-depth pipeline, so each data sample is aligned with its mode sample.
- FSM states: IDLE, LATCH, WRITE, READ. Each cycle, the state equals the synchronized mode.
- An action commits on leaving LATCH or WRITE, i.e. on the first cycle the synchronized mode differs. It uses the aligned data sampled in the last cycle in that state.
- A direct transition (e.g. LATCH→WRITE with no intervening IDLE) commits the exited state, then enters the new one.
- LATCH commit: if data[7:4]==CHIP_SEL, then addr<=data[3:0] and selected<=1; otherwise selected<=0 and addr is unchanged.
- WRITE commit, only when selected: reg[addr]<=data, masked per register:
  - R1/R3/R5/R13 keep 4 bits.
  - R6/R8/R9/R10 keep 5 bits.
  - All other registers keep 8 bits.
  - Unused bits are stored as 0.
- A write to R13 additionally sets env_restart for exactly one cycle, the cycle after commit, even when the value is unchanged.
- READ, only when selected:
  - d_out<=masked reg[addr].
  - R14 returns port_a_in when mixer[6]=0, otherwise port_a_out.
  - R15 returns port_b_in when mixer[7]=0, otherwise port_b_out.
  - d_out refreshes every cycle while in READ.
- d_oe=1 only while state is READ and selected, with d_out valid in the same cycle.
- Reset values:
  - All registers are 0.
  - addr=0, selected=1.
  - d_out=0, d_oe=0, env_restart=0.
  - FSM is IDLE and the sync pipelines are cleared.
- Reset during an operation discards any pending commit.
- Reset is asynchronous and takes effect immediately.

## Timing
- bc1/bdir edge to state change: SYNC_STAGES to SYNC_STAGES+1 clk cycles.
- Write visibility: a register output updates on the cycle after the synchronized mode leaves WRITE, i.e. SYNC_STAGES+1 cycles after bdir falls.
- Read: d_oe and d_out assert one cycle after entering READ and deassert one cycle after leaving it.
- Minimum bus phase: each mode must be held for at least 2 clk cycles, and data must be stable over that window. Shorter phases may be missed without corrupting state.
- Back-to-back latch then write with no IDLE gap is supported.

## Structure
- Package ay_pkg holds:
  - the mode enum (AY_INACT, AY_READ, AY_WRITE, AY_LATCH);
  - register index constants R_TONE_A_L … R_PORT_B;
  - the 16-entry width mask table.
- Sub-module ay_bus_sync contains the bc1/bdir synchronizer, the aligned data delay line and the mode decode.
- The FSM, register file and read mux live in ay_psg_regfile.

## Test plan
- Reset: after n_rst release, all outputs are 0, d_oe=0 and env_restart=0.
- Latch 0x07, write 0xFF → mixer=0xFF.
- Latch 0x01, write 0xFF → tone_a=12'hF00.
- Latch 0x00, write 0x34 → tone_a=12'hF34.
- Latch 0x0D, write 0x0A twice → env_shape=4'hA, with two single-cycle env_restart pulses.
- Latch 0x20 (chip not selected), then write 0x55 → no register changes; a subsequent read keeps d_oe=0.
- Read-back:
  - Mixer=0x00, port_a_in=0x5A, latch 0x0E, read → d_oe=1, d_out=0x5A.
  - Then set mixer=0x40 and write R14=0xC3; reading R14 → d_out=0xC3.
- Latch 0x08 directly followed by write 0xFF with no IDLE gap → vol_a=5'h1F.
- Asserting n_rst mid-write phase → no commit, and all outputs return to 0 immediately.
